// File: rtl/chacha_decrypt_core.sv
// chacha_decrypt_core: iterative ChaCha20 keystream generator that XORs keystream words 0-7
// onto a 256-bit ciphertext block.
// Optional build macro CHACHA_DEC_UNROLL_EN: four quarter-rounds (one full round) per cycle.
module chacha_decrypt_core (
  input  logic         clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [255:0] chacha_key,
  input  logic [127:0] chacha_nonce,
  input  logic [255:0] ciphertext,
  output logic [255:0] plaintext,
  output logic         Busy,
  output logic         Done
);

  typedef logic [15:0][31:0] state_t;
  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} fsm_e;

`ifdef CHACHA_DEC_UNROLL_EN
  localparam int QrPerCycle = 4;
  localparam logic [6:0] LastCnt = 7'd19;
`else
  localparam int QrPerCycle = 1;
  localparam logic [6:0] LastCnt = 7'd79;
`endif

  fsm_e          state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  state_t        work_q, work_d;
  state_t        saved_q, saved_d;
  logic [255:0]  ct_q, ct_d;
  logic [255:0]  pt_q, pt_d;
  state_t        init_state;
  state_t        round_next;
  logic [1:0]    lane_base;
  logic          diag_sel;

  function automatic logic [127:0] quarter_round(input logic [31:0] a_in, input logic [31:0] b_in,
                                                 input logic [31:0] c_in, input logic [31:0] d_in);
    logic [31:0] a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  // Lane l of a column round touches (l, 4+l, 8+l, 12+l); the diagonal round skews each row
  // by its row number, which reproduces (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
  function automatic state_t apply_qr(input state_t s, input logic [1:0] lane, input logic diag);
    logic [3:0]   ia, ib, ic, id;
    logic [127:0] r;
    state_t       o;
    ia = {2'd0, lane};
    ib = {2'd1, lane + {1'b0, diag}};
    ic = {2'd2, lane + {diag, 1'b0}};
    id = {2'd3, lane + {diag, diag}};
    r = quarter_round(s[ia], s[ib], s[ic], s[id]);
    o = s;
    o[ia] = r[127:96];
    o[ib] = r[95:64];
    o[ic] = r[63:32];
    o[id] = r[31:0];
    return o;
  endfunction

  // Initial ChaCha state: constants in words 0-3, key in 4-11, counter/nonce in 12-15.
  always_comb begin
    init_state = {chacha_nonce, chacha_key,
                  32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
  end

`ifdef CHACHA_DEC_UNROLL_EN
  assign lane_base = 2'd0;
  assign diag_sel  = cnt_q[0];
`else
  assign lane_base = cnt_q[1:0];
  assign diag_sel  = cnt_q[2];
`endif

  // Round datapath: QrPerCycle quarter-rounds on disjoint words, applied in sequence.
  always_comb begin
    round_next = work_q;
    for (int j = 0; j < QrPerCycle; j++) begin
      round_next = apply_qr(round_next, lane_base + 2'(j), diag_sel);
    end
  end

  // Next-state logic and datapath register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    saved_d = saved_q;
    ct_d    = ct_q;
    pt_d    = pt_q;
    case (state_q)
      StIdle: begin
        if (Start) begin
          state_d = StRound;
          work_d  = init_state;
          saved_d = init_state;
          ct_d    = ciphertext;
          cnt_d   = '0;
        end
      end
      StRound: begin
        work_d = round_next;
        cnt_d  = cnt_q + 7'd1;
        if (cnt_q == LastCnt) state_d = StFinal;
      end
      StFinal: begin
        for (int i = 0; i < 8; i++) begin
          pt_d[32*i +: 32] = ct_q[32*i +: 32] ^ (work_q[i] + saved_q[i]);
        end
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      work_q  <= '0;
      saved_q <= '0;
      ct_q    <= '0;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      saved_q <= saved_d;
      ct_q    <= ct_d;
      pt_q    <= pt_d;
    end
  end

  assign plaintext = pt_q;
  assign Busy      = (state_q == StRound) || (state_q == StFinal);
  assign Done      = (state_q == StDone);

endmodule

// File: tb/tb_chacha_decrypt_core.sv
// Directed bench for chacha_decrypt_core using the RFC 7539 2.3.2 keystream block.
module tb_chacha_decrypt_core;

`ifdef CHACHA_DEC_UNROLL_EN
  localparam int Lat = 22;
`else
  localparam int Lat = 82;
`endif

  logic         clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic [255:0] chacha_key;
  logic [127:0] chacha_nonce;
  logic [255:0] ciphertext;
  logic [255:0] plaintext;
  logic         Busy;
  logic         Done;

  always #10 clk = ~clk;

  chacha_decrypt_core dut (
    .clk          (clk),
    .Reset        (Reset),
    .Start        (Start),
    .chacha_key   (chacha_key),
    .chacha_nonce (chacha_nonce),
    .ciphertext   (ciphertext),
    .plaintext    (plaintext),
    .Busy         (Busy),
    .Done         (Done)
  );

  typedef struct {
    string        name;
    logic [255:0] ct;
    logic [255:0] exp_pt;
  } vec_t;

  vec_t         vecs[5];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [255:0] ks;
  logic [255:0] rfc_key;
  logic [127:0] rfc_nonce;
  logic [255:0] pat;
  logic [255:0] rnd;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse Start, scramble inputs after acceptance, and wait (bounded) for Done.
  task automatic run_block(input logic [255:0] ct, output int lat, output logic [255:0] pt,
                           output int busy_err);
    chacha_key   = rfc_key;
    chacha_nonce = rfc_nonce;
    ciphertext   = ct;
    Start        = 1'b1;
    tick();
    Start        = 1'b0;
    chacha_key   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    chacha_nonce = {$urandom, $urandom, $urandom, $urandom};
    ciphertext   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    lat      = -1;
    busy_err = 0;
    for (int k = 1; k <= Lat + 20; k++) begin
      if (k > 1) tick();
      if (Done) begin
        lat = k;
        if (Busy !== 1'b0) busy_err++;
        break;
      end
      if (Busy !== 1'b1) busy_err++;
    end
    pt = plaintext;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int           lat;
    int           busy_err;
    int           dones;
    int           done_at;
    int           d_pos[2];
    logic [255:0] pt;

    ks        = 256'h4e6cd4c3_9aaa2204_0368c033_c7f4d1c7_c47120a3_1fdd0f50_15593bd1_e4e7f110;
    rfc_key   = 256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;
    rfc_nonce = 128'h00000000_4a000000_09000000_00000001;
    pat       = {8{32'h5aa5_c33c}};
    rnd       = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};

    vecs[0] = '{name: "keystream",  ct: '0,   exp_pt: ks};
    vecs[1] = '{name: "involution", ct: ks,   exp_pt: '0};
    vecs[2] = '{name: "ones",       ct: '1,   exp_pt: ~ks};
    vecs[3] = '{name: "pattern",    ct: pat,  exp_pt: ks ^ pat};
    vecs[4] = '{name: "random",     ct: rnd,  exp_pt: ks ^ rnd};

    Reset        = 1'b1;
    Start        = 1'b0;
    chacha_key   = '0;
    chacha_nonce = '0;
    ciphertext   = '0;
    tick();
    tick();
    check("reset_pt", plaintext, '0);
    check_int("reset_busy", int'(Busy), 0);
    check_int("reset_done", int'(Done), 0);
    Reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (Done) dones++;
    end
    check_int("idle_no_done", dones, 0);

    for (int i = 0; i < 5; i++) begin
      run_block(vecs[i].ct, lat, pt, busy_err);
      check_int({vecs[i].name, "_latency"}, lat, Lat);
      check({vecs[i].name, "_pt"}, pt, vecs[i].exp_pt);
      check_int({vecs[i].name, "_busy"}, busy_err, 0);
      tick();
      check_int({vecs[i].name, "_done_pulse"}, int'(Done), 0);
    end

    // Start while busy: extra Start pulses with a different key must be ignored.
    chacha_key   = rfc_key;
    chacha_nonce = rfc_nonce;
    ciphertext   = '0;
    Start        = 1'b1;
    tick();
    dones   = 0;
    done_at = -1;
    for (int k = 1; k <= 2 * Lat + 5; k++) begin
      if (k > 1) tick();
      if (Done) begin
        dones++;
        if (done_at < 0) done_at = k;
      end
      if (k == Lat / 8 || k == Lat / 2) begin
        Start      = 1'b1;
        chacha_key = ~rfc_key;
        ciphertext = rnd;
      end else begin
        Start = 1'b0;
      end
    end
    check_int("busy_start_dones", dones, 1);
    check_int("busy_start_latency", done_at, Lat);
    check("busy_start_pt", plaintext, ks);

    // Mid-operation reset, with Start also high: reset wins.
    chacha_key   = rfc_key;
    chacha_nonce = rfc_nonce;
    ciphertext   = '0;
    Start        = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 2; k <= Lat * 5 / 8; k++) tick();
    Reset      = 1'b1;
    Start      = 1'b1;
    ciphertext = '1;
    tick();
    Reset = 1'b0;
    Start = 1'b0;
    check("midreset_pt", plaintext, '0);
    check_int("midreset_busy", int'(Busy), 0);
    check_int("midreset_done", int'(Done), 0);
    dones = 0;
    for (int k = 0; k < 2 * Lat; k++) begin
      tick();
      if (Done || Busy) dones++;
    end
    check_int("aborted_no_activity", dones, 0);
    run_block('1, lat, pt, busy_err);
    check_int("after_reset_latency", lat, Lat);
    check("after_reset_pt", pt, ~ks);

    // Back-to-back with Start held high.
    tick();
    chacha_key   = rfc_key;
    chacha_nonce = rfc_nonce;
    ciphertext   = '0;
    Start        = 1'b1;
    tick();
    dones    = 0;
    busy_err = 0;
    d_pos[0] = -1;
    d_pos[1] = -1;
    for (int k = 1; k <= 2 * Lat + 3; k++) begin
      logic exp_busy;
      if (k > 1) tick();
      exp_busy = !(k == Lat || k == Lat + 1 || k == 2 * Lat + 1 || k == 2 * Lat + 2);
      if (Busy !== exp_busy) busy_err++;
      if (Done) begin
        if (dones < 2) d_pos[dones] = k;
        dones++;
      end
    end
    check_int("b2b_dones", dones, 2);
    check_int("b2b_first_done", d_pos[0], Lat);
    check_int("b2b_second_done", d_pos[1], 2 * Lat + 1);
    check_int("b2b_busy", busy_err, 0);
    check("b2b_pt", plaintext, ks);
    Start = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
